// File: rtl/open_list_req_ctrl_if.sv
// Request/response and queue-strobe bundle for the open-list request front-end.
// Combinational only; carries enq/deq/rsp valid-ready plus queue strobes and flags.
// Backpressure is expressed through the ready/valid pairs carried here.
interface open_list_req_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CW         = 13
);
    logic                  i_enq_valid;
    logic [DATA_WIDTH-1:0] i_enq_f;
    logic                  o_enq_ready;
    logic                  i_deq_valid;
    logic                  o_deq_ready;
    logic                  o_rsp_valid;
    logic [DATA_WIDTH-1:0] o_rsp_f;
    logic                  i_rsp_ready;
    logic                  o_q_wrt;
    logic                  o_q_read;
    logic [DATA_WIDTH-1:0] o_q_node_f;
    logic                  i_q_full;
    logic                  i_q_empty;
    logic [DATA_WIDTH-1:0] i_q_head_f;
    logic [CW-1:0]         o_count;
    logic                  o_busy;

    modport slave (
        input  i_enq_valid, i_enq_f, i_deq_valid, i_rsp_ready,
               i_q_full, i_q_empty, i_q_head_f,
        output o_enq_ready, o_deq_ready, o_rsp_valid, o_rsp_f,
               o_q_wrt, o_q_read, o_q_node_f, o_count, o_busy
    );

    modport master (
        output i_enq_valid, i_enq_f, i_deq_valid, i_rsp_ready,
               i_q_full, i_q_empty, i_q_head_f,
        input  o_enq_ready, o_deq_ready, o_rsp_valid, o_rsp_f,
               o_q_wrt, o_q_read, o_q_node_f, o_count, o_busy
    );
endinterface

// File: rtl/open_list_req_ctrl.sv
// Merges enqueue and dequeue streams into min-queue strobes and returns popped heads.
// Latency: strobes and response one cycle after handshake; SETTLE_CYCLES+1 between queue ops.
// Backpressure: readies drop while settling, when full/empty, or when the response slot is occupied.
module open_list_req_ctrl #(
    parameter int QUEUE_SIZE    = 2048,
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int CW            = $clog2(2*QUEUE_SIZE+1)
) (
    input  logic               CLK,
    input  logic               RST,
    open_list_req_ctrl_if.slave bus
);
    localparam int         CAP       = 2*QUEUE_SIZE;
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    typedef enum logic [0:0] {ST_IDLE, ST_SETTLE} state_t;

    state_t                state;
    logic [3:0]            settle_cnt;
    logic [CW-1:0]         count_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_f_q;
    logic                  wrt_q;
    logic                  read_q;
    logic [DATA_WIDTH-1:0] node_f_q;

    logic is_open, rsp_free, enq_rdy, deq_rdy, enq_hs, deq_hs;
    logic do_push, do_pop, do_replace, do_bypass;

    // The enq side may still take a push while the response slot is blocked;
    // with both requests present and the slot free the pair is served together.
    always_comb begin
        is_open    = !RST && (state == ST_IDLE);
        rsp_free   = !rsp_valid_q || bus.i_rsp_ready;
        enq_rdy    = is_open && (!bus.i_q_full || (bus.i_deq_valid && rsp_free));
        deq_rdy    = is_open && rsp_free && (!bus.i_q_empty || bus.i_enq_valid);
        enq_hs     = bus.i_enq_valid && enq_rdy;
        deq_hs     = bus.i_deq_valid && deq_rdy;
        do_replace = enq_hs && deq_hs && !bus.i_q_empty;
        do_bypass  = enq_hs && deq_hs && bus.i_q_empty;
        do_pop     = deq_hs && !enq_hs;
        do_push    = enq_hs && !deq_hs;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            settle_cnt  <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_f_q     <= '0;
            wrt_q       <= 1'b0;
            read_q      <= 1'b0;
            node_f_q    <= '0;
        end else begin
            wrt_q  <= do_push || do_replace;
            read_q <= do_pop || do_replace;
            if (do_push || do_replace)
                node_f_q <= bus.i_enq_f;

            case (state)
                ST_IDLE: begin
                    if (do_push || do_pop || do_replace) begin
                        settle_cnt <= SETTLE_LD;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt <= 4'd1) begin
                        settle_cnt <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                default: begin
                    settle_cnt <= '0;
                    state      <= ST_IDLE;
                end
            endcase

            // Bypass answers from the enqueue data since the queue has nothing to offer.
            if (do_pop || do_replace) begin
                rsp_valid_q <= 1'b1;
                rsp_f_q     <= bus.i_q_head_f;
            end else if (do_bypass) begin
                rsp_valid_q <= 1'b1;
                rsp_f_q     <= bus.i_enq_f;
            end else if (bus.i_rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end

            if (do_push && (count_q < CW'(CAP)))
                count_q <= count_q + CW'(1);
            else if (do_pop && (count_q != '0))
                count_q <= count_q - CW'(1);
        end
    end

    assign bus.o_enq_ready = enq_rdy;
    assign bus.o_deq_ready = deq_rdy;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_f     = rsp_f_q;
    assign bus.o_q_wrt     = wrt_q;
    assign bus.o_q_read    = read_q;
    assign bus.o_q_node_f  = node_f_q;
    assign bus.o_count     = count_q;
    assign bus.o_busy      = (settle_cnt != '0) || rsp_valid_q;
endmodule

// File: tb/tb_open_list_req_ctrl.sv
// Bench for open_list_req_ctrl: behavioural min-queue environment, reference model,
// directed vector table, hand sequences for stalls/backpressure/reset, then random traffic.
module tb_open_list_req_ctrl;
    localparam int QS     = 4;
    localparam int DW     = 32;
    localparam int SETTLE = 2;
    localparam int CW     = $clog2(2*QS+1);
    localparam int CAP    = 2*QS;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    open_list_req_ctrl_if #(.DATA_WIDTH(DW), .CW(CW)) bus();

    open_list_req_ctrl #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .SETTLE_CYCLES(SETTLE), .CW(CW)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    // Behavioural min-queue standing in for the systolic array.
    int env_q[$];
    always @(negedge CLK) begin
        if (RST) begin
            env_q.delete();
        end else begin
            if (bus.o_q_read && env_q.size() > 0) void'(env_q.pop_front());
            if (bus.o_q_wrt) begin
                env_q.push_back(int'(bus.o_q_node_f));
                env_q.sort();
            end
        end
        bus.i_q_empty  = (env_q.size() == 0);
        bus.i_q_full   = (env_q.size() >= CAP);
        bus.i_q_head_f = (env_q.size() == 0) ? '1 : DW'(env_q[0]);
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: logical queue contents and response slot.
    typedef enum {OP_NONE, OP_PUSH, OP_POP, OP_REPL, OP_BYP} op_t;
    int          ref_q[$];
    bit          ref_pend;
    logic [31:0] ref_rsp;
    int          cyc;
    int          last_op;
    bit          exp_wrt, exp_rd;
    logic [31:0] exp_node;

    task automatic ref_reset();
        ref_q.delete();
        ref_pend = 0;
        ref_rsp  = 0;
        last_op  = -100;
        exp_wrt  = 0;
        exp_rd   = 0;
        exp_node = 0;
    endtask

    task automatic step(input bit ev, input logic [31:0] ef, input bit dv, input bit rr,
                        output bit er, output bit dr);
        op_t op;
        bit  open, rfree, emp, ful;
        bus.i_enq_valid = ev;
        bus.i_enq_f     = ef;
        bus.i_deq_valid = dv;
        bus.i_rsp_ready = rr;
        #1;
        er = bus.o_enq_ready;
        dr = bus.o_deq_ready;

        open  = (cyc - last_op) > SETTLE;
        rfree = !ref_pend || rr;
        emp   = (ref_q.size() == 0);
        ful   = (ref_q.size() >= CAP);
        op    = OP_NONE;
        if (open) begin
            if (ev && dv && !emp && rfree)     op = OP_REPL;
            else if (ev && dv && emp && rfree) op = OP_BYP;
            else if (dv && !emp && rfree)      op = OP_POP;
            else if (ev && !ful)               op = OP_PUSH;
        end
        if (ev) chk("ref_enq_ready", er, (op == OP_REPL || op == OP_BYP || op == OP_PUSH));
        if (dv) chk("ref_deq_ready", dr, (op == OP_REPL || op == OP_BYP || op == OP_POP));

        exp_wrt = (op == OP_PUSH || op == OP_REPL);
        exp_rd  = (op == OP_POP  || op == OP_REPL);
        if (exp_wrt) exp_node = ef;
        if (op == OP_POP || op == OP_REPL) begin
            ref_pend = 1;
            ref_rsp  = ref_q[0];
            void'(ref_q.pop_front());
        end else if (op == OP_BYP) begin
            ref_pend = 1;
            ref_rsp  = ef;
        end else if (rr) begin
            ref_pend = 0;
        end
        if (exp_wrt) begin
            ref_q.push_back(int'(ef));
            ref_q.sort();
        end
        if (op == OP_PUSH || op == OP_POP || op == OP_REPL) last_op = cyc;

        @(posedge CLK);
        #1;
        chk("ref_rsp_valid", bus.o_rsp_valid, ref_pend);
        if (ref_pend) chk("ref_rsp_f", bus.o_rsp_f, ref_rsp);
        chk("ref_q_wrt", bus.o_q_wrt, exp_wrt);
        chk("ref_q_read", bus.o_q_read, exp_rd);
        if (exp_wrt) chk("ref_q_node_f", bus.o_q_node_f, exp_node);
        chk("ref_count", bus.o_count, ref_q.size());
        chk("ref_busy", bus.o_busy, (((cyc + 1) - last_op) <= SETTLE) || ref_pend);
        if (!bus.o_q_wrt && !bus.o_q_read) chk("env_sync_count", bus.o_count, env_q.size());
        cyc++;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_enq_ready"}, bus.o_enq_ready, 0);
        chk({tag, "_deq_ready"}, bus.o_deq_ready, 0);
        chk({tag, "_rsp_valid"}, bus.o_rsp_valid, 0);
        chk({tag, "_rsp_f"},     bus.o_rsp_f, 0);
        chk({tag, "_q_wrt"},     bus.o_q_wrt, 0);
        chk({tag, "_q_read"},    bus.o_q_read, 0);
        chk({tag, "_q_node_f"},  bus.o_q_node_f, 0);
        chk({tag, "_count"},     bus.o_count, 0);
        chk({tag, "_busy"},      bus.o_busy, 0);
    endtask

    task automatic do_reset(input string tag);
        bus.i_enq_valid = 1;
        bus.i_enq_f     = 32'd99;
        bus.i_deq_valid = 1;
        bus.i_rsp_ready = 0;
        RST = 1;
        #1;
        chk_zero_outputs({tag, "_async"});
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk_zero_outputs({tag, "_held"});
        RST = 0;
        bus.i_enq_valid = 0;
        bus.i_deq_valid = 0;
        bus.i_rsp_ready = 1;
        ref_reset();
    endtask

    typedef struct {
        bit ev; logic [31:0] ef; bit dv; bit rr;
        bit er; bit dr;
        bit rv; logic [31:0] rf; bit wr; bit rd; int cnt;
    } vec_t;
    vec_t tbl[26];

    initial begin
        bit er, dr;
        bit pe, pd, rr;
        logic [31:0] pf;

        // push 5,3,9; pop x3; bypass 7; push 4; replace with 2; pop
        tbl[0]  = '{1, 5, 0, 1, 1, 0, 0, 0, 1, 0, 1};
        tbl[1]  = '{1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[2]  = '{1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{1, 3, 0, 1, 1, 0, 0, 0, 1, 0, 2};
        tbl[4]  = '{1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 2};
        tbl[5]  = '{1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 2};
        tbl[6]  = '{1, 9, 0, 1, 1, 0, 0, 0, 1, 0, 3};
        tbl[7]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3};
        tbl[8]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3};
        tbl[9]  = '{0, 0, 1, 1, 0, 1, 1, 3, 0, 1, 2};
        tbl[10] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2};
        tbl[11] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2};
        tbl[12] = '{0, 0, 1, 1, 0, 1, 1, 5, 0, 1, 1};
        tbl[13] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[14] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[15] = '{0, 0, 1, 1, 0, 1, 1, 9, 0, 1, 0};
        tbl[16] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[17] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[18] = '{1, 7, 1, 1, 1, 1, 1, 7, 0, 0, 0};
        tbl[19] = '{1, 4, 0, 1, 1, 0, 0, 0, 1, 0, 1};
        tbl[20] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[21] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[22] = '{1, 2, 1, 1, 1, 1, 1, 4, 1, 1, 1};
        tbl[23] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[24] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[25] = '{0, 0, 1, 1, 0, 1, 1, 2, 0, 1, 0};

        bus.i_enq_valid = 0;
        bus.i_enq_f     = 0;
        bus.i_deq_valid = 0;
        bus.i_rsp_ready = 1;
        cyc = 0;
        ref_reset();
        #1;
        do_reset("reset");

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].ev, tbl[i].ef, tbl[i].dv, tbl[i].rr, er, dr);
            if (tbl[i].ev) chk("tbl_enq_ready", er, tbl[i].er);
            if (tbl[i].dv) chk("tbl_deq_ready", dr, tbl[i].dr);
            chk("tbl_rsp_valid", bus.o_rsp_valid, tbl[i].rv);
            if (tbl[i].rv) chk("tbl_rsp_f", bus.o_rsp_f, tbl[i].rf);
            chk("tbl_q_wrt", bus.o_q_wrt, tbl[i].wr);
            chk("tbl_q_read", bus.o_q_read, tbl[i].rd);
            chk("tbl_count", bus.o_count, tbl[i].cnt);
        end

        // Dequeue against an empty queue stalls, then an enqueue bypasses.
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 1, er, dr);
            chk("empty_deq_ready", dr, 0);
            chk("empty_deq_strobe", bus.o_q_wrt | bus.o_q_read, 0);
        end
        step(1, 6, 1, 1, er, dr);
        chk("bypass_enq_ready", er, 1);
        chk("bypass_deq_ready", dr, 1);
        chk("bypass_rsp_valid", bus.o_rsp_valid, 1);
        chk("bypass_rsp_f", bus.o_rsp_f, 6);
        chk("bypass_no_strobe", bus.o_q_wrt | bus.o_q_read, 0);

        // Blocked response slot: deq refused, push still accepted.
        step(1, 10, 0, 1, er, dr);
        step(0, 0, 0, 1, er, dr);
        step(0, 0, 0, 1, er, dr);
        step(1, 20, 0, 1, er, dr);
        step(0, 0, 0, 1, er, dr);
        step(0, 0, 0, 1, er, dr);
        step(0, 0, 1, 0, er, dr);
        chk("pend_pop_accept", dr, 1);
        chk("pend_pop_rsp_f", bus.o_rsp_f, 10);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, er, dr);
            chk("pend_deq_blocked", dr, 0);
            chk("pend_rsp_hold", bus.o_rsp_f, 10);
        end
        step(1, 30, 1, 0, er, dr);
        chk("pend_push_ready", er, 1);
        chk("pend_deq_still_blocked", dr, 0);
        chk("pend_push_strobe", bus.o_q_wrt, 1);
        chk("pend_count", bus.o_count, 2);

        // Reset while a strobe and a response are outstanding.
        do_reset("midop");

        pe = 0; pd = 0; pf = 0;
        for (int i = 0; i < 1500; i++) begin
            bit enq_phase;
            enq_phase = ((i / 300) % 2) == 0;
            if (!pe) begin
                pe = $urandom_range(0, 99) < (enq_phase ? 70 : 30);
                pf = $urandom_range(0, 60);
            end
            if (!pd) pd = $urandom_range(0, 99) < (enq_phase ? 30 : 70);
            rr = $urandom_range(0, 99) < 75;
            step(pe, pf, pd, rr, er, dr);
            if (pe && er) pe = 0;
            if (pd && dr) pd = 0;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
